dwa_selector: RTL and testbench

- Parametrised, clocked element selector for the unary DAC array.
- Converts an input code k into a k-hot enable vector across N_ELEM unit elements.
- Two modes:
  - Fixed thermometer mode: elements 0..k-1.
  - Data-weighted-averaging (DWA) mode: a rotating start pointer cycles element usage to first-order shape element mismatch.
- Sits between the modulator/quantiser output and the analog element switches.

---
 rtl/dwa_selector.sv | 131 +++++++++++++
 tb/tb_dwa_selector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dwa_selector.sv
// rtl/dwa_selector.sv - unary DAC element selector, thermometer or data-weighted-averaging rotation
//
// Purpose:
//   Turns a requested element count (code) into a k-hot enable vector over
//   N_ELEM unit elements. In thermometer mode the lowest k elements are used.
//   In DWA mode a rotating start pointer spreads element usage so that
//   element mismatch is first-order shaped.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   block enable; low forces sel_out to zero, keeps ptr/overrange
//   mode       in   0 = thermometer, 1 = DWA rotation
//   in_valid   in   code qualifier
//   code       in   requested number of active elements (saturated to N_ELEM)
//   ptr_clr    in   synchronous pointer clear (present only with DWA_PTR_CLR_EN)
//   sel_out    out  registered element enables
//   out_valid  out  sel_out updated on this edge
//   ptr        out  rotation pointer, next start element
//   overrange  out  last accepted code exceeded N_ELEM
//
// Optional feature macro: DWA_PTR_CLR_EN (adds ptr_clr).

module dwa_selector #(
  parameter int N_ELEM = 18,
  parameter int CODE_W = 5,
  parameter int PTR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] code,
`ifdef DWA_PTR_CLR_EN
  input  logic              ptr_clr,
`endif
  output logic [N_ELEM-1:0] sel_out,
  output logic              out_valid,
  output logic [PTR_W-1:0]  ptr,
  output logic              overrange
);

  localparam logic [CODE_W-1:0] N_CODE = CODE_W'(N_ELEM);
  localparam logic [PTR_W:0]    N_PTR  = (PTR_W + 1)'(N_ELEM);

  logic [N_ELEM-1:0] sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              overrange_q, overrange_d;

  logic                accept;
  logic                code_over;
  logic [CODE_W-1:0]   k;
  logic [N_ELEM-1:0]   therm;
  logic [2*N_ELEM-1:0] rot_wide;
  logic [N_ELEM-1:0]   rot;
  logic [PTR_W:0]      ptr_sum;
  logic [PTR_W-1:0]    ptr_next;
  logic                clr;

`ifdef DWA_PTR_CLR_EN
  assign clr = ptr_clr;
`else
  assign clr = 1'b0;
`endif

  assign accept    = en & in_valid;
  assign code_over = (code > N_CODE);
  assign k         = code_over ? N_CODE : code;

  // Lowest k bits set; k never exceeds N_ELEM after saturation.
  always_comb begin
    therm = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      therm[i] = (CODE_W'(i) < k);
    end
  end

  // Rotate the thermometer mask left by ptr within N_ELEM bits: shift into a
  // double-width vector and fold the overflow back onto the low half.
  assign rot_wide = {{N_ELEM{1'b0}}, therm} << ptr_q;
  assign rot      = rot_wide[N_ELEM-1:0] | rot_wide[2*N_ELEM-1:N_ELEM];

  // ptr + k is at most 2*N_ELEM-1, so one conditional subtract wraps it.
  assign ptr_sum  = {1'b0, ptr_q} + (PTR_W + 1)'(k);
  assign ptr_next = (ptr_sum >= N_PTR) ? PTR_W'(ptr_sum - N_PTR) : PTR_W'(ptr_sum);

  always_comb begin
    sel_d       = sel_q;
    out_valid_d = 1'b0;
    ptr_d       = ptr_q;
    overrange_d = overrange_q;
    if (!en) begin
      sel_d = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      overrange_d = code_over;
      if (mode) begin
        sel_d = rot;
        ptr_d = ptr_next;
      end else begin
        sel_d = therm;
      end
    end
    // Clear wins over the pointer update; sel_d above already used the old ptr.
    if (clr) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      overrange_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      overrange_q <= overrange_d;
    end
  end

  assign sel_out   = sel_q;
  assign out_valid = out_valid_q;
  assign ptr       = ptr_q;
  assign overrange = overrange_q;

endmodule

// File: tb/tb_dwa_selector.sv
// tb/tb_dwa_selector.sv - self-checking bench for dwa_selector

module tb_dwa_selector;

  localparam int N_ELEM = 18;
  localparam int CODE_W = 5;
  localparam int PTR_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic [CODE_W-1:0] code = '0;
  logic              ptr_clr = 1'b0;
  logic [N_ELEM-1:0] sel_out;
  logic              out_valid;
  logic [PTR_W-1:0]  ptr;
  logic              overrange;

  int tests = 0;
  int fails = 0;

  dwa_selector #(.N_ELEM(N_ELEM), .CODE_W(CODE_W), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .code      (code),
`ifdef DWA_PTR_CLR_EN
    .ptr_clr   (ptr_clr),
`endif
    .sel_out   (sel_out),
    .out_valid (out_valid),
    .ptr       (ptr),
    .overrange (overrange)
  );

  always #5 clk = ~clk;

  // Reference model: element indices counted out one by one with modulo arithmetic.
  int          m_ptr = 0;
  logic [63:0] m_sel = '0;
  logic        m_vld = 1'b0;
  logic        m_ovr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int kk;
    int start;
    if (!rst_n) begin
      m_ptr = 0;
      m_sel = '0;
      m_vld = 1'b0;
      m_ovr = 1'b0;
    end else begin
      start = m_ptr;
      if (!en) begin
        m_sel = '0;
        m_vld = 1'b0;
      end else if (in_valid) begin
        kk    = (int'(code) > N_ELEM) ? N_ELEM : int'(code);
        m_ovr = (int'(code) > N_ELEM);
        m_vld = 1'b1;
        m_sel = '0;
        for (int j = 0; j < kk; j++) begin
          if (mode) m_sel[(start + j) % N_ELEM] = 1'b1;
          else      m_sel[j] = 1'b1;
        end
        if (mode) m_ptr = (start + kk) % N_ELEM;
      end else begin
        m_vld = 1'b0;
      end
`ifdef DWA_PTR_CLR_EN
      if (ptr_clr) m_ptr = 0;
`endif
    end
  end

  always @(negedge clk) begin
    tests++;
    if (64'(sel_out) !== m_sel || out_valid !== m_vld || int'(ptr) != m_ptr || overrange !== m_ovr) begin
      fails++;
      $display("FAIL model t=%0t sel got %h exp %h vld got %b exp %b ptr got %0d exp %0d ovr got %b exp %b",
               $time, sel_out, m_sel[N_ELEM-1:0], out_valid, m_vld, ptr, m_ptr, overrange, m_ovr);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic m, input logic v, input int c);
    @(negedge clk);
    en       = e;
    mode     = m;
    in_valid = v;
    code     = CODE_W'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [63:0] s, input int p, input logic v, input logic o);
    chk({name, ".sel"}, 64'(sel_out), s);
    chk({name, ".ptr"}, 64'(ptr), 64'(p));
    chk({name, ".vld"}, 64'(out_valid), 64'(v));
    chk({name, ".ovr"}, 64'(overrange), 64'(o));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0);
    chk_all("reset_idle", 64'h0, 0, 0, 0);

    drive(1, 1, 1, 5);
    chk_all("dwa5", 64'h0001F, 5, 1, 0);
    drive(1, 1, 1, 15);
    chk_all("dwa15_wrap", 64'h3FFE3, 2, 1, 0);

    drive(1, 1, 1, 18);
    chk_all("full18", 64'h3FFFF, 2, 1, 0);
    drive(1, 1, 1, 25);
    chk_all("over25", 64'h3FFFF, 2, 1, 1);
    drive(1, 1, 1, 0);
    chk_all("zero", 64'h0, 2, 1, 0);

    drive(1, 1, 1, 5);
    chk_all("to_ptr7", 64'h0007C, 7, 1, 0);
    drive(1, 0, 1, 3);
    chk_all("therm3", 64'h00007, 7, 1, 0);
    drive(1, 1, 1, 3);
    chk_all("dwa3_resume", 64'h00380, 10, 1, 0);

    drive(0, 1, 1, 7);
    chk_all("disabled", 64'h0, 10, 0, 0);
    drive(1, 1, 1, 2);
    chk_all("reenable2", 64'h00C00, 12, 1, 0);
    drive(1, 1, 0, 9);
    chk_all("hold_novalid", 64'h00C00, 12, 0, 0);
    drive(1, 1, 1, 31);
    chk_all("over31", 64'h3FFFF, 12, 1, 1);
    drive(1, 1, 0, 0);
    chk_all("ovr_hold", 64'h3FFFF, 12, 0, 1);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 64'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 4);
    chk_all("after_rst", 64'h0000F, 4, 1, 0);

`ifdef DWA_PTR_CLR_EN
    @(negedge clk);
    ptr_clr  = 1'b1;
    en       = 1'b1;
    mode     = 1'b1;
    in_valid = 1'b1;
    code     = CODE_W'(3);
    @(posedge clk);
    #1;
    chk_all("clr_same", 64'h00070, 0, 1, 0);
    @(negedge clk);
    ptr_clr = 1'b0;
    drive(1, 1, 1, 3);
    chk_all("clr_next", 64'h00007, 3, 1, 0);
`endif

    // Mixed sweep checked by the model on every cycle.
    for (int i = 0; i < 60; i++) begin
      drive((i % 11) != 10, (i % 7) != 3, (i % 5) != 4, (i * 7 + 3) % 32);
    end
    drive(1, 1, 1, N_ELEM);
    drive(1, 1, 1, N_ELEM + 1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
